// File: rtl/ldpc_ctrl_pkg.sv
// Shared control definitions for the layered LDPC decoder: state encodings,
// parameter defaults and a helper for sizing the VNU update timer.
package ldpc_ctrl_pkg;

  typedef enum logic [2:0] {
    LIC_IDLE    = 3'd0,
    LIC_RUN     = 3'd1,
    LIC_VNU_UPD = 3'd2,
    LIC_DONE    = 3'd3,
    LIC_TERM    = 3'd4
  } lic_state_t;

  localparam int LAYER_NUM_DEF        = 3;
  localparam int MAX_ITER_DEF         = 10;
  localparam int VNU_UPDATE_CYCLE_DEF = 5;

  // Counter width able to hold cycles-1, never narrower than one bit.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/vnu_upd_timer.sv
// Loadable down-counter that times the VNU IB-RAM update window; saturates at
// zero and flags it.
module vnu_upd_timer #(
  parameter int W = 3
) (
  input  logic         read_clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge read_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/layer_iter_ctrl.sv
// Layer/iteration sequencer for the layered decoder: times the VNU update
// window, counts layers and iterations, and decides frame termination.
// Optional: define EARLY_TERM_EN to let syndrome_ok end a frame before MAX_ITER.
module layer_iter_ctrl
  import ldpc_ctrl_pkg::*;
#(
  parameter int LAYER_NUM        = LAYER_NUM_DEF,
  parameter int MAX_ITER         = MAX_ITER_DEF,
  parameter int VNU_UPDATE_CYCLE = VNU_UPDATE_CYCLE_DEF,
  parameter int ITER_W           = $clog2(MAX_ITER + 1)
) (
  input  logic                 read_clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 c2v_mem_we,
  input  logic                 syndrome_ok,
  output logic                 layer_finish,
  output logic                 vnu_update_pend,
  output logic                 termination,
  output logic                 frame_done,
  output logic                 decode_fail,
  output logic [LAYER_NUM-1:0] layer_onehot,
  output logic [ITER_W-1:0]    iter_cnt,
  output logic                 wb_overrun
);

  localparam int TMR_W = timer_width(VNU_UPDATE_CYCLE);

  lic_state_t       state;
  logic             tmr_load;
  logic             tmr_zero;
  logic [TMR_W-1:0] tmr_load_val;
  logic             last_layer;
  logic             limit_hit;
  logic             stop;

  assign tmr_load     = (state == LIC_RUN) && c2v_mem_we;
  assign tmr_load_val = TMR_W'(VNU_UPDATE_CYCLE - 1);
  assign last_layer   = layer_onehot[LAYER_NUM-1];
  // Compares the count as it will be after this layer's increment.
  assign limit_hit    = (iter_cnt + ITER_W'(1)) == ITER_W'(MAX_ITER);

`ifdef EARLY_TERM_EN
  assign stop = last_layer && (syndrome_ok || limit_hit);
`else
  assign stop = last_layer && limit_hit;
`endif

  vnu_upd_timer #(
    .W (TMR_W)
  ) u_timer (
    .read_clk (read_clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge read_clk or posedge rst) begin
    if (rst) begin
      state           <= LIC_IDLE;
      layer_finish    <= 1'b0;
      vnu_update_pend <= 1'b0;
      termination     <= 1'b0;
      frame_done      <= 1'b0;
      decode_fail     <= 1'b0;
      layer_onehot    <= LAYER_NUM'(1);
      iter_cnt        <= '0;
      wb_overrun      <= 1'b0;
    end else begin
      layer_finish <= 1'b0;
      termination  <= 1'b0;

      // A write-back arriving outside RUN is dropped but remembered.
      if (c2v_mem_we && (state != LIC_RUN)) begin
        wb_overrun <= 1'b1;
      end

      case (state)
        LIC_IDLE: begin
          if (frame_start) begin
            state        <= LIC_RUN;
            layer_onehot <= LAYER_NUM'(1);
            iter_cnt     <= '0;
            frame_done   <= 1'b0;
            decode_fail  <= 1'b0;
          end
        end

        LIC_RUN: begin
          if (c2v_mem_we) begin
            state           <= LIC_VNU_UPD;
            vnu_update_pend <= 1'b1;
          end
        end

        LIC_VNU_UPD: begin
          if (tmr_zero) begin
            state           <= LIC_DONE;
            vnu_update_pend <= 1'b0;
            layer_finish    <= 1'b1;
          end
        end

        LIC_DONE: begin
          layer_onehot <= (layer_onehot << 1) | LAYER_NUM'(layer_onehot[LAYER_NUM-1]);
          if (last_layer) begin
            iter_cnt <= iter_cnt + ITER_W'(1);
          end
          if (stop) begin
            state       <= LIC_TERM;
            termination <= 1'b1;
            frame_done  <= 1'b1;
            decode_fail <= ~syndrome_ok;
          end else begin
            state <= LIC_RUN;
          end
        end

        LIC_TERM: state <= LIC_IDLE;

        default: state <= LIC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_iter_ctrl.sv
// Randomized scoreboard bench for layer_iter_ctrl: the driver predicts each
// layer_finish/termination event, a monitor matches them as the DUT emits them.
module tb_layer_iter_ctrl;

  localparam int N_LAYER = 3;
  localparam int N_ITER  = 2;
  localparam int V_CYC   = 5;
  localparam int IW      = $clog2(N_ITER + 1);
`ifdef EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum {EV_LF, EV_TERM} ev_kind_e;
  typedef struct {
    ev_kind_e           kind;
    int                 cyc;
    logic [N_LAYER-1:0] onehot;
    int                 iter;
    bit                 fail;
  } ev_t;

  logic               read_clk = 1'b0;
  logic               rst = 1'b1;
  logic               frame_start = 1'b0;
  logic               c2v_mem_we = 1'b0;
  logic               syndrome_ok = 1'b0;
  logic               layer_finish;
  logic               vnu_update_pend;
  logic               termination;
  logic               frame_done;
  logic               decode_fail;
  logic [N_LAYER-1:0] layer_onehot;
  logic [IW-1:0]      iter_cnt;
  logic               wb_overrun;

  int  n_pass = 0;
  int  n_total = 0;
  int  cyc = 0;
  bit  exp_overrun = 1'b0;
  ev_t sb[$];

  layer_iter_ctrl #(
    .LAYER_NUM        (N_LAYER),
    .MAX_ITER         (N_ITER),
    .VNU_UPDATE_CYCLE (V_CYC)
  ) dut (
    .read_clk        (read_clk),
    .rst             (rst),
    .frame_start     (frame_start),
    .c2v_mem_we      (c2v_mem_we),
    .syndrome_ok     (syndrome_ok),
    .layer_finish    (layer_finish),
    .vnu_update_pend (vnu_update_pend),
    .termination     (termination),
    .frame_done      (frame_done),
    .decode_fail     (decode_fail),
    .layer_onehot    (layer_onehot),
    .iter_cnt        (iter_cnt),
    .wb_overrun      (wb_overrun)
  );

  always #5 read_clk = ~read_clk;
  always @(posedge read_clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic tick;
    @(posedge read_clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT emits an event.
  int  pend_run = 0;
  int  last_run = 0;
  ev_t mon_e;
  always @(negedge read_clk) begin
    if (rst) begin
      pend_run = 0;
    end else begin
      if (vnu_update_pend) begin
        pend_run++;
      end else begin
        if (pend_run != 0) last_run = pend_run;
        pend_run = 0;
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("event_missed_at", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (layer_finish || termination) begin
        if (sb.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("event_cycle", cyc, mon_e.cyc);
          if (mon_e.kind == EV_LF) begin
            check("lf_flag", layer_finish, 1);
            check("lf_onehot", layer_onehot, mon_e.onehot);
            check("lf_iter", iter_cnt, mon_e.iter);
            check("pend_len", last_run, V_CYC);
          end else begin
            check("term_flag", termination, 1);
            check("term_iter", iter_cnt, mon_e.iter);
            check("term_frame_done", frame_done, 1);
            check("term_decode_fail", decode_fail, mon_e.fail);
          end
        end
      end
    end
  end

  // syn_mode: 0 random syndrome, 1 never ok, 2 ok on every last layer.
  task automatic run_frame(input int syn_mode);
    int  layer, iter, t, ov_at;
    bit  syn, last, stop, exp_fail;
    ev_t e;
    layer = 0; iter = 0; stop = 1'b0; exp_fail = 1'b0;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    while (!stop) begin
      repeat ($urandom_range(0, 3)) begin
        frame_start = ($urandom_range(0, 3) == 0);
        tick;
      end
      frame_start = 1'b0;
      c2v_mem_we  = 1'b1;
      t = cyc;
      e.kind = EV_LF; e.cyc = t + V_CYC + 1; e.onehot = N_LAYER'(1 << layer);
      e.iter = iter; e.fail = 1'b0;
      sb.push_back(e);
      ov_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, V_CYC) : 0;
      if (ov_at != 0) exp_overrun = 1'b1;
      for (int j = 1; j <= V_CYC; j++) begin
        tick;
        c2v_mem_we = (j == ov_at);
      end
      tick;
      c2v_mem_we = 1'b0;
      last = (layer == N_LAYER - 1);
      case (syn_mode)
        0:       syn = ($urandom_range(0, 2) == 0);
        1:       syn = 1'b0;
        default: syn = last;
      endcase
      syndrome_ok = syn;
      if (last) begin
        iter++;
        stop = (iter == N_ITER) || (EARLY && syn);
      end
      layer = (layer + 1) % N_LAYER;
      if (stop) begin
        exp_fail = !syn;
        e.kind = EV_TERM; e.cyc = t + V_CYC + 2; e.iter = iter; e.fail = exp_fail;
        sb.push_back(e);
      end
      tick;
      syndrome_ok = 1'b0;
    end
    tick;
    check("idle_frame_done", frame_done, 1);
    check("idle_decode_fail", decode_fail, exp_fail);
    check("idle_iter", iter_cnt, iter);
    check("idle_onehot", layer_onehot, 1);
    check("wb_overrun", wb_overrun, exp_overrun);
  endtask

  initial begin
    repeat (3) tick;
    rst = 1'b0;
    tick;
    check("rst_onehot", layer_onehot, 1);
    check("rst_iter", iter_cnt, 0);
    check("rst_outputs", {layer_finish, vnu_update_pend, termination,
                          frame_done, decode_fail, wb_overrun}, 0);

    run_frame(1);
    run_frame(2);

    // Reset in the middle of a VNU update window, with overrun already set.
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    c2v_mem_we  = 1'b1;
    tick;
    tick;
    c2v_mem_we = 1'b0;
    check("pre_rst_pend", vnu_update_pend, 1);
    check("pre_rst_overrun", wb_overrun, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_onehot", layer_onehot, 1);
    check("async_rst_iter", iter_cnt, 0);
    check("async_rst_outputs", {layer_finish, vnu_update_pend, termination,
                                frame_done, decode_fail, wb_overrun}, 0);
    exp_overrun = 1'b0;
    tick;
    rst = 1'b0;
    tick;

    for (int f = 0; f < 8; f++) run_frame(0);

    repeat (4) tick;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    n_total++;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
